mac_sequencer: RTL and testbench

Sequences the MAC datapath over a vector of N operand pairs. Each job runs as follows:
- accept a START/LEN job;
- clear the accumulator;
- step an operand-memory address counter while enabling accumulation, with the enable aligned to the memory read latency;
- report completion with a DONE/ACK handshake.

The block replaces the fixed-count run gating in front of the MAC unit with a length-programmable controller.

---
 rtl/mac_sequencer.sv | 165 ++++++++++++++++
 tb/tb_mac_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// Length-programmable run controller for the MAC datapath: clear, issue N reads, drain, then DONE/ACK.
// Build option: define MAC_SEQUENCER_ABORT_EN to add the ABORT_IN job-cancel input.
module mac_sequencer #(
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RESET_IN,
    input  logic              START_IN,
    input  logic [ADDR_W:0]   LEN_IN,
    input  logic              ACK_IN,
`ifdef MAC_SEQUENCER_ABORT_EN
    input  logic              ABORT_IN,
`endif
    output logic [ADDR_W-1:0] ADDR_OUT,
    output logic              ACC_CLR_OUT,
    output logic              ACC_EN_OUT,
    output logic              BUSY_OUT,
    output logic              DONE_OUT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] LEN_MAX    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [1:0]      DRAIN_LAST = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    state_t            state;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        drain_cnt;
    logic              issue_q;
    logic              clr_q;
    logic              busy_q;
    logic              done_q;
    logic              last_issue;
    logic              abort_req;
    logic              abort_hit;

`ifdef MAC_SEQUENCER_ABORT_EN
    assign abort_req = ABORT_IN;
`else
    assign abort_req = 1'b0;
`endif

    assign abort_hit  = abort_req && (state == S_CLEAR || state == S_RUN || state == S_DRAIN);
    assign last_issue = ({1'b0, addr_q} == (len_q - 1'b1));

    // Control FSM; every output is a register updated alongside the state.
    always_ff @(posedge CLK or negedge RESET_IN) begin
        if (!RESET_IN) begin
            state     <= S_IDLE;
            len_q     <= '0;
            addr_q    <= '0;
            drain_cnt <= '0;
            issue_q   <= 1'b0;
            clr_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (abort_hit) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            issue_q <= 1'b0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START_IN) begin
                        len_q  <= (LEN_IN > LEN_MAX) ? LEN_MAX : LEN_IN;
                        addr_q <= '0;
                        clr_q  <= 1'b1;
                        busy_q <= 1'b1;
                        state  <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    clr_q <= 1'b0;
                    if (len_q != '0) begin
                        issue_q <= 1'b1;
                        state   <= S_RUN;
                    end else begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_RUN: begin
                    if (last_issue) begin
                        // Address holds on the last entry until the job is handed back.
                        issue_q <= 1'b0;
                        if (RD_LAT > 0) begin
                            drain_cnt <= DRAIN_LAST;
                            state     <= S_DRAIN;
                        end else begin
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == 2'd0) begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                S_DONE: begin
                    if (ACK_IN) begin
                        addr_q <= '0;
                        done_q <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    addr_q  <= '0;
                    issue_q <= 1'b0;
                    clr_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Enable chain: delays each issue strobe by the memory read latency.
    generate
        if (RD_LAT == 0) begin : g_no_lat
            assign ACC_EN_OUT = issue_q;
        end else begin : g_lat
            logic [RD_LAT-1:0] en_chain;

            always_ff @(posedge CLK or negedge RESET_IN) begin
                if (!RESET_IN) begin
                    en_chain <= '0;
                end else if (abort_hit) begin
                    en_chain <= '0;
                end else begin
                    en_chain[0] <= issue_q;
                    for (int k = 1; k < RD_LAT; k++) begin
                        en_chain[k] <= en_chain[k-1];
                    end
                end
            end

            assign ACC_EN_OUT = en_chain[RD_LAT-1];
        end
    endgenerate

    assign ADDR_OUT    = addr_q;
    assign ACC_CLR_OUT = clr_q;
    assign BUSY_OUT    = busy_q;
    assign DONE_OUT    = done_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: four instances (RD_LAT 0..3) driven by shared stimulus.
module tb_mac_sequencer;

    logic       CLK;
    logic       RESET_IN;
    logic       START_IN;
    logic [4:0] LEN_IN;
    logic       ACK_IN;
`ifdef MAC_SEQUENCER_ABORT_EN
    logic       abort_in;
`endif

    logic [3:0] addr_o [4];
    logic       clr_o  [4];
    logic       en_o   [4];
    logic       busy_o [4];
    logic       done_o [4];

    logic [31:0] sb_q [$];
    int n_tests;
    int n_fail;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mac_sequencer #(.ADDR_W(4), .RD_LAT(g)) dut (
            .CLK        (CLK),
            .RESET_IN   (RESET_IN),
            .START_IN   (START_IN),
            .LEN_IN     (LEN_IN),
            .ACK_IN     (ACK_IN),
`ifdef MAC_SEQUENCER_ABORT_EN
            .ABORT_IN   (abort_in),
`endif
            .ADDR_OUT   (addr_o[g]),
            .ACC_CLR_OUT(clr_o[g]),
            .ACC_EN_OUT (en_o[g]),
            .BUSY_OUT   (busy_o[g]),
            .DONE_OUT   (done_o[g])
        );
    end

    // Packed view, instance 0 in the top byte: {clr, en, busy, done, addr[3:0]} per instance.
    function automatic logic [31:0] sample();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            v = {v[23:0], clr_o[i], en_o[i], busy_o[i], done_o[i], addr_o[i]};
        end
        return v;
    endfunction

    // Expected outputs k cycles after the START-sampling edge; ACK is sampled at the end of cycle t_last.
    function automatic logic [7:0] exp_cyc(int len, int lat, int k, int t_last);
        logic       clr, en, busy, done;
        logic [3:0] a;
        int         d;
        if (k > t_last) return 8'h00;
        d    = (len == 0) ? 1 : 1 + len + lat;
        clr  = (k == 0);
        en   = (len > 0) && (k >= 1 + lat) && (k <= len + lat);
        busy = 1'b1;
        done = (k >= d);
        if (k >= 1 && k <= len)   a = 4'(k - 1);
        else if (k > len && len > 0) a = 4'(len - 1);
        else                      a = 4'd0;
        return {clr, en, busy, done, a};
    endfunction

    function automatic int last_cycle(int len, int hold);
        return ((len == 0) ? 1 : 4 + len) + hold;
    endfunction

    task automatic push_job(int len, int t_last, int k_end);
        logic [31:0] v;
        for (int k = 0; k <= k_end; k++) begin
            v = '0;
            for (int lat = 0; lat < 4; lat++) v = {v[23:0], exp_cyc(len, lat, k, t_last)};
            sb_q.push_back(v);
        end
    endtask

    task automatic start_job(int len_in, int len_eff, int t_last);
        @(negedge CLK);
        START_IN = 1'b1;
        LEN_IN   = 5'(len_in);
        push_job(len_eff, t_last, t_last + 1);
    endtask

    task automatic test_reset();
        logic [31:0] got;
        RESET_IN = 1'b0;
        START_IN = 1'b0;
        LEN_IN   = '0;
        ACK_IN   = 1'b0;
`ifdef MAC_SEQUENCER_ABORT_EN
        abort_in = 1'b0;
`endif
        repeat (2) @(negedge CLK);
        got = sample();
        n_tests++;
        if (got !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state got %h want %h", got, 32'h0);
        end
        RESET_IN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            got = sample();
            n_tests++;
            if (got !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_idle k=%0d got %h want %h", k, got, 32'h0);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] got;
        @(negedge CLK);
        START_IN = 1'b1;
        LEN_IN   = 5'd5;
        for (int k = 0; k <= 3; k++) begin
            @(negedge CLK);
            START_IN = 1'b0;
        end
        n_tests++;
        if (addr_o[1] !== 4'd2 || busy_o[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_pre addr=%0d busy=%b want addr=2 busy=1", addr_o[1], busy_o[1]);
        end
        #1 RESET_IN = 1'b0;
        #1 got = sample();
        n_tests++;
        if (got !== 32'h0) begin
            n_fail++;
            $display("FAIL midrun_async_reset got %h want %h", got, 32'h0);
        end
        @(negedge CLK);
        RESET_IN = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            got = sample();
            n_tests++;
            if (got !== 32'h0) begin
                n_fail++;
                $display("FAIL midrun_after k=%0d got %h want %h", k, got, 32'h0);
            end
        end
    endtask

    task automatic test_job(string name, int len_in, int len_eff, int hold);
        logic [31:0] got, want;
        int t_last;
        t_last = last_cycle(len_eff, hold);
        start_job(len_in, len_eff, t_last);
        for (int k = 0; sb_q.size() > 0; k++) begin
            @(negedge CLK);
            START_IN = 1'b0;
            got  = sample();
            want = sb_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s k=%0d got %h want %h", name, k, got, want);
            end
            ACK_IN = (k == t_last);
        end
        ACK_IN = 1'b0;
    endtask

    task automatic test_start_during_run();
        logic [31:0] got, want;
        int t_last;
        t_last = last_cycle(4, 2);
        start_job(4, 4, t_last);
        for (int k = 0; sb_q.size() > 0; k++) begin
            @(negedge CLK);
            got  = sample();
            want = sb_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL start_in_run k=%0d got %h want %h", k, got, want);
            end
            START_IN = (k == 2);
            LEN_IN   = (k == 2) ? 5'd9 : 5'd4;
            ACK_IN   = (k == t_last);
        end
        ACK_IN = 1'b0;
    endtask

    task automatic test_start_ack_collision();
        logic [31:0] got, want;
        int t_last;
        t_last = last_cycle(2, 1);
        start_job(2, 2, t_last);
        for (int lat = 0; lat < 5; lat++) sb_q.push_back(32'h0);
        for (int k = 0; sb_q.size() > 0; k++) begin
            @(negedge CLK);
            START_IN = 1'b0;
            got  = sample();
            want = sb_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL start_ack_collide k=%0d got %h want %h", k, got, want);
            end
            ACK_IN   = (k == t_last);
            START_IN = (k == t_last);
        end
        ACK_IN = 1'b0;
    endtask

`ifdef MAC_SEQUENCER_ABORT_EN
    task automatic test_abort();
        logic [31:0] got, want;
        @(negedge CLK);
        START_IN = 1'b1;
        LEN_IN   = 5'd8;
        push_job(8, 1000, 4);
        for (int lat = 0; lat < 10; lat++) sb_q.push_back(32'h0);
        for (int k = 0; sb_q.size() > 0; k++) begin
            @(negedge CLK);
            START_IN = 1'b0;
            got  = sample();
            want = sb_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL abort k=%0d got %h want %h", k, got, want);
            end
            abort_in = (k == 4);
        end
        abort_in = 1'b0;
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_reset_mid_run();
        test_job("nominal_len5", 5, 5, 10);
        test_job("len_zero", 0, 0, 2);
        test_job("len_clamp31", 31, 16, 1);
        test_job("len3", 3, 3, 0);
        test_job("len_max16", 16, 16, 0);
        test_job("len1_back_to_back", 1, 1, 0);
        test_start_during_run();
        test_start_ack_collision();
`ifdef MAC_SEQUENCER_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
